// File: rtl/lcd1602_pkg.sv
// Shared constants, state encoding and helpers for the LCD1602 bus monitor.
// Instruction classes are identified by a mask/opcode pair: the highest set bit decides.
package lcd1602_pkg;

    localparam logic [7:0] BLANK_CHAR = 8'h20;

    localparam logic [6:0] DDRAM_LINE0_END   = 7'h27;
    localparam logic [6:0] DDRAM_LINE1_START = 7'h40;
    localparam logic [6:0] DDRAM_LINE1_END   = 7'h67;

    localparam logic [7:0] MASK_SET_DDRAM  = 8'h80;
    localparam logic [7:0] OP_SET_DDRAM    = 8'h80;
    localparam logic [7:0] MASK_SET_CGRAM  = 8'hC0;
    localparam logic [7:0] OP_SET_CGRAM    = 8'h40;
    localparam logic [7:0] MASK_FUNC_SET   = 8'hE0;
    localparam logic [7:0] OP_FUNC_SET     = 8'h20;
    localparam logic [7:0] MASK_SHIFT      = 8'hF0;
    localparam logic [7:0] OP_SHIFT        = 8'h10;
    localparam logic [7:0] MASK_DISP_CTRL  = 8'hF8;
    localparam logic [7:0] OP_DISP_CTRL    = 8'h08;
    localparam logic [7:0] MASK_ENTRY_MODE = 8'hFC;
    localparam logic [7:0] OP_ENTRY_MODE   = 8'h04;
    localparam logic [7:0] MASK_HOME       = 8'hFE;
    localparam logic [7:0] OP_HOME         = 8'h02;
    localparam logic [7:0] MASK_CLEAR      = 8'hFF;
    localparam logic [7:0] OP_CLEAR        = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_CLEARING = 2'd2
    } state_t;

    function automatic int unsigned us_to_cycles(input int unsigned clock_freq, input int unsigned us);
        return (clock_freq / 1_000_000) * us;
    endfunction

    // DDRAM address counter step, wrapping between the two 40-byte line windows.
    function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
        if (inc) begin
            if (a == DDRAM_LINE0_END) return DDRAM_LINE1_START;
            if (a == DDRAM_LINE1_END) return 7'h00;
            return a + 7'd1;
        end
        if (a == 7'h00)             return DDRAM_LINE1_END;
        if (a == DDRAM_LINE1_START) return DDRAM_LINE0_END;
        return a - 7'd1;
    endfunction

endpackage

// File: rtl/lcd1602_bus_monitor_sampler.sv
// Bus front end: synchronises RS/RW/E/DATA and qualifies falling edges of E
// whose preceding high run was long enough to count as a real transfer.
module lcd_bus_sampler #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_E_HIGH  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_e,
    input  logic [7:0] lcd_data,
    output logic       xfer_stb,
    output logic       xfer_rs,
    output logic       xfer_rw,
    output logic [7:0] xfer_data
);
    localparam int BUS_W  = 11;
    localparam int HCNT_W = $clog2(MIN_E_HIGH + 1);

    logic [BUS_W-1:0]  sync_reg [SYNC_STAGES];
    logic [BUS_W-1:0]  synced;
    logic              e_synced;
    logic [HCNT_W-1:0] high_cnt_reg;
    logic [9:0]        capture_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= '0;
        end else begin
            for (int i = SYNC_STAGES - 1; i > 0; i--) sync_reg[i] <= sync_reg[i-1];
            sync_reg[0] <= {lcd_e, lcd_rs, lcd_rw, lcd_data};
        end
    end

    assign synced   = sync_reg[SYNC_STAGES-1];
    assign e_synced = synced[10];

    // High-run counter saturates at the qualifying width; the capture tracks
    // the bus on every high cycle, so it holds the last-high-cycle values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_cnt_reg <= '0;
            capture_reg  <= '0;
        end else if (e_synced) begin
            if (high_cnt_reg != HCNT_W'(MIN_E_HIGH)) high_cnt_reg <= high_cnt_reg + 1'b1;
            capture_reg <= synced[9:0];
        end else begin
            high_cnt_reg <= '0;
        end
    end

    assign xfer_stb  = !e_synced && (high_cnt_reg == HCNT_W'(MIN_E_HIGH));
    assign xfer_rs   = capture_reg[9];
    assign xfer_rw   = capture_reg[8];
    assign xfer_data = capture_reg[7:0];

endmodule

// File: rtl/lcd1602_bus_monitor.sv
// Receive-only HD44780 responder: decodes the 8-bit bus into a 32-char shadow
// DDRAM plus display state, emulates busy timing and flags protocol misuse.
module lcd1602_bus_monitor
    import lcd1602_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ  = 50_000_000,
    parameter int          SYNC_STAGES = 2,
    parameter int          MIN_E_HIGH  = 10,
    parameter int unsigned EXEC_US     = 37,
    parameter int unsigned CLEAR_US    = 1520
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_e,
    input  logic [7:0] lcd_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic [6:0] cursor_addr,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       busy,
    output logic       cmd_valid,
    output logic       char_valid,
    output logic [7:0] code,
    output logic       overrun,
    output logic       proto_err
);
    localparam int unsigned EXEC_CYCLES  = us_to_cycles(CLOCK_FREQ, EXEC_US);
    localparam int unsigned CLEAR_CYCLES = us_to_cycles(CLOCK_FREQ, CLEAR_US);
    localparam int          CNT_W        = $clog2(CLEAR_CYCLES + 1);

    logic       xfer_stb, xfer_rs, xfer_rw;
    logic [7:0] xfer_data;

    lcd_bus_sampler #(
        .SYNC_STAGES(SYNC_STAGES),
        .MIN_E_HIGH (MIN_E_HIGH)
    ) u_sampler (
        .clk      (clk),
        .rst      (rst),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_e    (lcd_e),
        .lcd_data (lcd_data),
        .xfer_stb (xfer_stb),
        .xfer_rs  (xfer_rs),
        .xfer_rw  (xfer_rw),
        .xfer_data(xfer_data)
    );

    state_t     state_reg;
    logic       pend_rs_reg;
    logic [7:0] pend_data_reg;
    logic [6:0] cursor_reg, cursor_next;
    logic       id_reg, id_next;
    logic       cgram_reg, cgram_next;
    logic       disp_reg, cur_reg, blink_reg;
    logic       disp_next, cur_next, blink_next;
    logic [7:0] code_reg;
    logic       overrun_reg, proto_err_reg;
    logic [CNT_W-1:0] busy_cnt_reg;
    logic [4:0] clr_idx_reg;
    logic       proto_set, long_busy, go_clear, data_we;

    logic [7:0] shadow [32];
    logic [7:0] rd_char_reg;
    logic       shadow_we;
    logic [4:0] shadow_waddr;
    logic [7:0] shadow_wdata;

    assign busy = (state_reg == ST_EXEC) || (busy_cnt_reg != '0);

    // Decode of the pending transfer; only committed in the EXEC cycle.
    always_comb begin
        cursor_next = cursor_reg;
        id_next     = id_reg;
        cgram_next  = cgram_reg;
        disp_next   = disp_reg;
        cur_next    = cur_reg;
        blink_next  = blink_reg;
        proto_set   = 1'b0;
        long_busy   = 1'b0;
        go_clear    = 1'b0;
        data_we     = 1'b0;
        if (pend_rs_reg) begin
            data_we     = !cgram_reg && (cursor_reg[5:4] == 2'b00);
            cursor_next = step_addr(cursor_reg, id_reg);
        end else if ((pend_data_reg & MASK_SET_DDRAM) == OP_SET_DDRAM) begin
            cursor_next = pend_data_reg[6:0];
            cgram_next  = 1'b0;
        end else if ((pend_data_reg & MASK_SET_CGRAM) == OP_SET_CGRAM) begin
            cgram_next = 1'b1;
        end else if ((pend_data_reg & MASK_FUNC_SET) == OP_FUNC_SET) begin
            proto_set = !pend_data_reg[4];
        end else if ((pend_data_reg & MASK_SHIFT) == OP_SHIFT) begin
            if (!pend_data_reg[3]) cursor_next = step_addr(cursor_reg, pend_data_reg[2]);
        end else if ((pend_data_reg & MASK_DISP_CTRL) == OP_DISP_CTRL) begin
            disp_next  = pend_data_reg[2];
            cur_next   = pend_data_reg[1];
            blink_next = pend_data_reg[0];
        end else if ((pend_data_reg & MASK_ENTRY_MODE) == OP_ENTRY_MODE) begin
            id_next = pend_data_reg[1];
        end else if ((pend_data_reg & MASK_HOME) == OP_HOME) begin
            cursor_next = 7'h00;
            long_busy   = 1'b1;
        end else if ((pend_data_reg & MASK_CLEAR) == OP_CLEAR) begin
            cursor_next = 7'h00;
            id_next     = 1'b1;
            long_busy   = 1'b1;
            go_clear    = 1'b1;
        end
    end

    always_comb begin
        shadow_we    = 1'b0;
        shadow_waddr = {cursor_reg[6], cursor_reg[3:0]};
        shadow_wdata = pend_data_reg;
        if (state_reg == ST_EXEC) begin
            shadow_we = data_we;
        end else if (state_reg == ST_CLEARING) begin
            shadow_we    = 1'b1;
            shadow_waddr = clr_idx_reg;
            shadow_wdata = BLANK_CHAR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            pend_rs_reg   <= 1'b0;
            pend_data_reg <= '0;
            cursor_reg    <= '0;
            id_reg        <= 1'b1;
            cgram_reg     <= 1'b0;
            disp_reg      <= 1'b0;
            cur_reg       <= 1'b0;
            blink_reg     <= 1'b0;
            code_reg      <= '0;
            overrun_reg   <= 1'b0;
            proto_err_reg <= 1'b0;
            busy_cnt_reg  <= '0;
            clr_idx_reg   <= '0;
        end else begin
            if (xfer_stb && busy)    overrun_reg   <= 1'b1;
            if (xfer_stb && xfer_rw) proto_err_reg <= 1'b1;
            if (busy_cnt_reg != '0)  busy_cnt_reg  <= busy_cnt_reg - 1'b1;
            case (state_reg)
                ST_IDLE: begin
                    if (xfer_stb && !xfer_rw && !busy) begin
                        pend_rs_reg   <= xfer_rs;
                        pend_data_reg <= xfer_data;
                        state_reg     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    cursor_reg   <= cursor_next;
                    id_reg       <= id_next;
                    cgram_reg    <= cgram_next;
                    disp_reg     <= disp_next;
                    cur_reg      <= cur_next;
                    blink_reg    <= blink_next;
                    code_reg     <= pend_data_reg;
                    if (proto_set) proto_err_reg <= 1'b1;
                    // EXEC itself is the first busy cycle, hence the -1.
                    busy_cnt_reg <= long_busy ? CNT_W'(CLEAR_CYCLES - 1) : CNT_W'(EXEC_CYCLES - 1);
                    clr_idx_reg  <= '0;
                    state_reg    <= go_clear ? ST_CLEARING : ST_IDLE;
                end
                ST_CLEARING: begin
                    clr_idx_reg <= clr_idx_reg + 5'd1;
                    if (clr_idx_reg == 5'd31) state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) shadow[i] <= BLANK_CHAR;
            rd_char_reg <= '0;
        end else begin
            if (shadow_we) shadow[shadow_waddr] <= shadow_wdata;
            rd_char_reg <= shadow[rd_addr];
        end
    end

    assign rd_char     = rd_char_reg;
    assign cursor_addr = cursor_reg;
    assign disp_on     = disp_reg;
    assign cursor_on   = cur_reg;
    assign blink_on    = blink_reg;
    assign cmd_valid   = (state_reg == ST_EXEC) && !pend_rs_reg;
    assign char_valid  = (state_reg == ST_EXEC) && pend_rs_reg;
    assign code        = code_reg;
    assign overrun     = overrun_reg;
    assign proto_err   = proto_err_reg;

endmodule

// File: tb/tb_lcd1602_bus_monitor.sv
// Directed bench for lcd1602_bus_monitor, run at a 10 MHz clock parameter
// so busy times are 370 (exec) and 15200 (clear/home) cycles.
`timescale 1ns/1ps
module tb_lcd1602_bus_monitor;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_e = 1'b0;
    logic [7:0] lcd_data = 8'h00;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] rd_char, code;
    logic [6:0] cursor_addr;
    logic       disp_on, cursor_on, blink_on, busy, cmd_valid, char_valid, overrun, proto_err;

    int checks = 0, errors = 0;
    int n_cmd = 0, n_char = 0, run_len = 0, last_run = 0;
    int base_char, base_cmd;
    logic [7:0] v;

    always #5 clk = ~clk;

    lcd1602_bus_monitor #(.CLOCK_FREQ(10_000_000)) dut (
        .clk(clk), .rst(rst), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
        .lcd_data(lcd_data), .rd_addr(rd_addr), .rd_char(rd_char),
        .cursor_addr(cursor_addr), .disp_on(disp_on), .cursor_on(cursor_on),
        .blink_on(blink_on), .busy(busy), .cmd_valid(cmd_valid),
        .char_valid(char_valid), .code(code), .overrun(overrun), .proto_err(proto_err)
    );

    // Strobe counters and busy run-length measurement.
    always @(negedge clk) begin
        if (rst) begin
            run_len = 0;
        end else begin
            if (cmd_valid)  n_cmd++;
            if (char_valid) n_char++;
            if (busy) run_len++;
            else if (run_len != 0) begin
                last_run = run_len;
                run_len  = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic bus_xfer(input logic rs, input logic rw, input logic [7:0] d, input int width);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
        repeat (width) @(negedge clk);
        lcd_e = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("idle_in_time", {31'd0, busy}, 32'd0);
    endtask

    task automatic wr(input logic rs, input logic [7:0] d);
        bus_xfer(rs, 1'b0, d, 12);
        wait_idle(20000);
    endtask

    task automatic rd(input logic [4:0] a, output logic [7:0] val);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        val = rd_char;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", {1'b0, rd_char, cursor_addr, disp_on, cursor_on, blink_on, busy,
                                cmd_valid, char_valid, code, overrun, proto_err}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rd(5'd3, v);
        check("reset_shadow_blank", {24'd0, v}, 32'h20);

        // Init sequence and two characters
        wr(1'b0, 8'h38);
        wr(1'b0, 8'h0C);
        wr(1'b0, 8'h06);
        bus_xfer(1'b1, 1'b0, 8'h41, 12);
        check("busy_after_write", {31'd0, busy}, 32'd1);
        wait_idle(20000);
        check("exec_busy_cycles", last_run, 32'd370);
        wr(1'b1, 8'h42);
        check("cmd_count", n_cmd, 32'd3);
        check("char_count", n_char, 32'd2);
        rd(5'd0, v);  check("shadow0_A", {24'd0, v}, 32'h41);
        rd(5'd1, v);  check("shadow1_B", {24'd0, v}, 32'h42);
        check("cursor_after_AB", {25'd0, cursor_addr}, 32'h02);
        check("disp_ctrl", {29'd0, disp_on, cursor_on, blink_on}, 32'h4);
        check("code_last", {24'd0, code}, 32'h42);
        check("no_proto_err_dl1", {31'd0, proto_err}, 32'd0);

        // Second line
        wr(1'b0, 8'hC5);
        wr(1'b1, 8'h37);
        rd(5'd21, v); check("shadow21_7", {24'd0, v}, 32'h37);
        check("cursor_line2", {25'd0, cursor_addr}, 32'h46);

        // Invisible column 0x0F -> 0x10
        wr(1'b0, 8'h8F);
        wr(1'b1, 8'h58);
        check("cursor_0f_step", {25'd0, cursor_addr}, 32'h10);
        rd(5'd15, v); check("shadow15_visible_write", {24'd0, v}, 32'h58);

        // Line-end wrap 0x27 -> 0x40
        wr(1'b0, 8'hA7);
        wr(1'b1, 8'h59);
        check("cursor_wrap_27", {25'd0, cursor_addr}, 32'h40);
        rd(5'd7, v);  check("shadow7_untouched", {24'd0, v}, 32'h20);

        // Clear display
        bus_xfer(1'b0, 1'b0, 8'h01, 12);
        wait_idle(20000);
        check("clear_busy_cycles", last_run, 32'd15200);
        check("cursor_after_clear", {25'd0, cursor_addr}, 32'h00);
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), v);
            check($sformatf("clear_blank_%0d", i), {24'd0, v}, 32'h20);
        end

        // Overrun: second write ~100 cycles after an accepted one
        base_char = n_char;
        bus_xfer(1'b1, 1'b0, 8'h51, 12);
        repeat (82) @(negedge clk);
        bus_xfer(1'b1, 1'b0, 8'h52, 12);
        check("overrun_set", {31'd0, overrun}, 32'd1);
        check("overrun_char_count", n_char - base_char, 32'd1);
        wait_idle(20000);
        check("overrun_cursor", {25'd0, cursor_addr}, 32'h01);
        rd(5'd1, v);  check("overrun_shadow1", {24'd0, v}, 32'h20);
        repeat (1900) @(negedge clk);
        bus_xfer(1'b1, 1'b0, 8'h52, 12);
        wait_idle(20000);
        rd(5'd1, v);  check("late_write_shadow1", {24'd0, v}, 32'h52);
        check("late_write_cursor", {25'd0, cursor_addr}, 32'h02);

        // E width qualification
        base_char = n_char;
        bus_xfer(1'b1, 1'b0, 8'h53, 5);
        repeat (10) @(negedge clk);
        check("short_e_no_strobe", n_char - base_char, 32'd0);
        check("short_e_cursor", {25'd0, cursor_addr}, 32'h02);
        bus_xfer(1'b1, 1'b0, 8'h53, 12);
        wait_idle(20000);
        check("e12_one_strobe", n_char - base_char, 32'd1);
        rd(5'd2, v);  check("e12_shadow2", {24'd0, v}, 32'h53);

        // RW=1 read attempt
        base_char = n_char;
        base_cmd  = n_cmd;
        check("proto_before_rw", {31'd0, proto_err}, 32'd0);
        bus_xfer(1'b1, 1'b1, 8'h54, 12);
        repeat (5) @(negedge clk);
        check("proto_rw", {31'd0, proto_err}, 32'd1);
        check("rw_ignored", (n_char - base_char) + (n_cmd - base_cmd), 32'd0);
        check("rw_cursor", {25'd0, cursor_addr}, 32'h03);

        // Reset in the middle of a clear
        wr(1'b0, 8'hCF);
        wr(1'b1, 8'h5A);
        rd(5'd31, v); check("shadow31_Z", {24'd0, v}, 32'h5A);
        bus_xfer(1'b0, 1'b0, 8'h01, 12);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midclear_reset_outputs", {1'b0, rd_char, cursor_addr, disp_on, cursor_on, blink_on,
                                         busy, cmd_valid, char_valid, code, overrun, proto_err}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rd(5'd31, v); check("reset_shadow31", {24'd0, v}, 32'h20);
        base_char = n_char;
        wr(1'b1, 8'h4B);
        check("post_reset_char", n_char - base_char, 32'd1);
        rd(5'd0, v);  check("post_reset_shadow0", {24'd0, v}, 32'h4B);
        check("post_reset_cursor", {25'd0, cursor_addr}, 32'h01);
        wr(1'b0, 8'h28);
        check("proto_dl0", {31'd0, proto_err}, 32'd1);
        check("code_28", {24'd0, code}, 32'h28);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
